// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: turns the keypad scanner's key_done/key_code outputs into
// keystroke events and assembles them into a multi-digit code. Key E clears
// the buffer and key F commits it. A committed code is held on a valid/ready
// handshake until the consumer takes it. An inactivity timeout abandons
// partial entries.
module keypad_entry_ctrl #(
  parameter int unsigned NDIGITS = 4,   // buffer depth in digits, 1..15
  parameter int unsigned MIN_LOW = 2,   // low ticks needed before a rise counts
  parameter int unsigned TIMEOUT = 500  // stroke-free ticks before abandoning
) (
  input  logic                   rst,
  input  logic                   wClk20ms,
  input  logic                   key_done,
  input  logic [3:0]             key_code,
  input  logic                   code_ready,
  output logic [4*NDIGITS-1:0]   code,
  output logic [3:0]             code_len,
  output logic                   code_valid,
  output logic                   entry_busy,
  output logic                   overflow,
  output logic                   timeout_pulse
);

  localparam int unsigned CODE_W = 4 * NDIGITS;
  localparam int unsigned LOW_W  = (MIN_LOW < 1) ? 1 : $clog2(MIN_LOW + 1);
  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_DELIVER
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [3:0]          code_len_q, code_len_d;
  logic                code_valid_q, code_valid_d;
  logic                overflow_q, overflow_d;
  logic                timeout_pulse_q, timeout_pulse_d;
  logic                entry_busy_q;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic                done_q;
  logic [LOW_W-1:0]    low_cnt_q, low_cnt_d;
  logic                stroke;
  logic                is_digit, is_clear, is_enter;
  logic [CODE_W-1:0]   code_shifted;

  // Low-run counter: saturates once the low period is long enough to qualify.
  always_comb begin
    if (key_done) begin
      low_cnt_d = '0;
    end else if (low_cnt_q < LOW_W'(MIN_LOW)) begin
      low_cnt_d = low_cnt_q + LOW_W'(1);
    end else begin
      low_cnt_d = low_cnt_q;
    end
  end

  // Keystroke detector state: previous key_done and the preceding low run.
  always_ff @(posedge wClk20ms or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b1;
      low_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values.
      done_q    <= key_done;
      low_cnt_q <= low_cnt_d;
    end
  end

  // A rise of key_done after a long enough low period is one keystroke.
  assign stroke   = key_done & ~done_q & (low_cnt_q >= LOW_W'(MIN_LOW));
  assign is_clear = (key_code == 4'hE);
  assign is_enter = (key_code == 4'hF);
  assign is_digit = ~is_clear & ~is_enter;

  // Newest digit enters at the low nibble; the oldest falls off the top.
  assign code_shifted = (code_q << 4) | CODE_W'(key_code);

  // Next-state and buffer update for the entry sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d         = state_q;
    code_d          = code_q;
    code_len_d      = code_len_q;
    code_valid_d    = code_valid_q;
    overflow_d      = overflow_q;
    timeout_pulse_d = 1'b0;
    idle_cnt_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (stroke && is_digit) begin
          code_d     = code_shifted;
          code_len_d = 4'd1;
          state_d    = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (stroke) begin
          if (is_clear) begin
            code_d     = '0;
            code_len_d = 4'd0;
            overflow_d = 1'b0;
            state_d    = ST_IDLE;
          end else if (is_enter) begin
            code_valid_d = 1'b1;
            state_d      = ST_DELIVER;
          end else if (code_len_q < 4'(NDIGITS)) begin
            code_d     = code_shifted;
            code_len_d = code_len_q + 4'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          // Stroke-free for TIMEOUT ticks: abandon the partial entry.
          code_d          = '0;
          code_len_d      = 4'd0;
          overflow_d      = 1'b0;
          timeout_pulse_d = 1'b1;
          state_d         = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      ST_DELIVER: begin
        // Buffer is frozen; any keystroke here is discarded.
        if (code_ready) begin
          code_d       = '0;
          code_len_d   = 4'd0;
          code_valid_d = 1'b0;
          overflow_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers, including the registered entry_busy flag.
  always_ff @(posedge wClk20ms or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      code_q          <= '0;
      code_len_q      <= 4'd0;
      code_valid_q    <= 1'b0;
      overflow_q      <= 1'b0;
      timeout_pulse_q <= 1'b0;
      entry_busy_q    <= 1'b0;
      idle_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      code_q          <= code_d;
      code_len_q      <= code_len_d;
      code_valid_q    <= code_valid_d;
      overflow_q      <= overflow_d;
      timeout_pulse_q <= timeout_pulse_d;
      entry_busy_q    <= (state_d == ST_ENTRY);
      idle_cnt_q      <= idle_cnt_d;
    end
  end

  assign code          = code_q;
  assign code_len      = code_len_q;
  assign code_valid    = code_valid_q;
  assign entry_busy    = entry_busy_q;
  assign overflow      = overflow_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios followed by random keying,
// all compared each tick against a queue-based model of the entry rules.
module tb_keypad_entry_ctrl;

  localparam int NDIGITS = 4;
  localparam int MIN_LOW = 2;
  localparam int TIMEOUT = 5;

  logic                 rst;
  logic                 wClk20ms;
  logic                 key_done;
  logic [3:0]           key_code;
  logic                 code_ready;
  logic [4*NDIGITS-1:0] code;
  logic [3:0]           code_len;
  logic                 code_valid;
  logic                 entry_busy;
  logic                 overflow;
  logic                 timeout_pulse;

  keypad_entry_ctrl #(
    .NDIGITS(NDIGITS),
    .MIN_LOW(MIN_LOW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rst          (rst),
    .wClk20ms     (wClk20ms),
    .key_done     (key_done),
    .key_code     (key_code),
    .code_ready   (code_ready),
    .code         (code),
    .code_len     (code_len),
    .code_valid   (code_valid),
    .entry_busy   (entry_busy),
    .overflow     (overflow),
    .timeout_pulse(timeout_pulse)
  );

  initial wClk20ms = 1'b0;
  always #5 wClk20ms = ~wClk20ms;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: digits as a queue, oldest first.
  typedef enum {M_IDLE, M_ENTRY, M_DELIVER} mode_t;
  mode_t      m_mode;
  logic [3:0] m_digits[$];
  bit         m_ovf, m_valid, m_tpulse, m_prev_done;
  int         m_low_run, m_silent;

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_digits.delete();
    m_ovf = 0; m_valid = 0; m_tpulse = 0;
    m_prev_done = 1; m_low_run = 0; m_silent = 0;
  endfunction

  function automatic void model_abandon();
    m_digits.delete();
    m_ovf  = 0;
    m_mode = M_IDLE;
  endfunction

  function automatic void model_edge(input bit kd, input logic [3:0] kc, input bit rdy);
    bit stroke;
    stroke      = kd && !m_prev_done && (m_low_run >= MIN_LOW);
    m_low_run   = kd ? 0 : m_low_run + 1;
    m_prev_done = kd;
    m_tpulse    = 0;
    case (m_mode)
      M_IDLE: begin
        if (stroke && kc < 4'hE) begin
          m_digits.push_back(kc);
          m_mode   = M_ENTRY;
          m_silent = 0;
        end
      end
      M_ENTRY: begin
        if (stroke) begin
          m_silent = 0;
          if (kc == 4'hE) model_abandon();
          else if (kc == 4'hF) begin
            m_valid = 1;
            m_mode  = M_DELIVER;
          end else if (m_digits.size() < NDIGITS) m_digits.push_back(kc);
          else m_ovf = 1;
        end else begin
          m_silent++;
          if (m_silent == TIMEOUT) begin
            model_abandon();
            m_tpulse = 1;
          end
        end
      end
      M_DELIVER: begin
        if (rdy) begin
          m_valid = 0;
          model_abandon();
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [63:0] model_code();
    logic [63:0] c = 0;
    foreach (m_digits[i]) c = (c << 4) | 64'(m_digits[i]);
    return c;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".code"},  64'(code),          model_code());
    check({tag, ".len"},   64'(code_len),      64'(m_digits.size()));
    check({tag, ".valid"}, 64'(code_valid),    64'(m_valid));
    check({tag, ".busy"},  64'(entry_busy),    64'(m_mode == M_ENTRY));
    check({tag, ".ovf"},   64'(overflow),      64'(m_ovf));
    check({tag, ".tpul"},  64'(timeout_pulse), 64'(m_tpulse));
  endtask

  // One tick: drive after the falling edge, model the rising edge, compare on the next fall.
  task automatic step(input bit kd, input logic [3:0] kc, input bit rdy);
    key_done   = kd;
    key_code   = kc;
    code_ready = rdy;
    @(posedge wClk20ms);
    model_edge(kd, kc, rdy);
    @(negedge wClk20ms);
    compare_all("step");
  endtask

  // Key press: 'lows' held ticks, then release carrying the key code.
  task automatic press(input logic [3:0] kc, input int lows, input int highs, input bit rdy_on_rise);
    for (int i = 0; i < lows; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
    step(1'b1, kc, rdy_on_rise);
    for (int i = 1; i < highs; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".code"},  64'(code),          64'h0);
    check({tag, ".len"},   64'(code_len),      64'h0);
    check({tag, ".valid"}, 64'(code_valid),    64'h0);
    check({tag, ".busy"},  64'(entry_busy),    64'h0);
    check({tag, ".ovf"},   64'(overflow),      64'h0);
    check({tag, ".tpul"},  64'(timeout_pulse), 64'h0);
  endtask

  initial begin
    rst        = 1'b1;
    key_done   = 1'b1;
    key_code   = 4'h0;
    code_ready = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    @(posedge wClk20ms);
    @(posedge wClk20ms);
    @(negedge wClk20ms);
    check_reset_outputs("reset");
    rst = 1'b1;

    // 1: digits 1,2,3 then ENTER, held until the consumer accepts.
    press(4'h1, 3, 1, 0);
    press(4'h2, 3, 1, 0);
    press(4'h3, 3, 1, 0);
    press(4'hF, 3, 1, 0);
    check("t1.code", 64'(code), 64'h0123);
    check("t1.len", 64'(code_len), 64'd3);
    for (int i = 0; i < 8; i++) step(1'b1, 4'h0, 1'b0);
    check("t1.valid_held", 64'(code_valid), 64'd1);
    step(1'b1, 4'h0, 1'b1);
    check("t1.accept_valid", 64'(code_valid), 64'd0);
    check("t1.accept_code", 64'(code), 64'h0);

    // 2: overflow drops the fifth digit, CLEAR empties everything.
    press(4'h5, 3, 1, 0);
    press(4'h6, 3, 1, 0);
    press(4'h7, 3, 1, 0);
    press(4'h8, 3, 1, 0);
    press(4'h9, 3, 1, 0);
    check("t2.code", 64'(code), 64'h5678);
    check("t2.len", 64'(code_len), 64'd4);
    check("t2.ovf", 64'(overflow), 64'd1);
    press(4'hE, 3, 1, 0);
    check("t2.clr_len", 64'(code_len), 64'd0);
    check("t2.clr_ovf", 64'(overflow), 64'd0);

    // 3: a one-tick low is a glitch; a two-tick low is a keystroke.
    press(4'h3, 1, 1, 0);
    check("t3.glitch_len", 64'(code_len), 64'd0);
    press(4'h3, 2, 1, 0);
    check("t3.stroke_len", 64'(code_len), 64'd1);
    check("t3.stroke_code", 64'(code), 64'h3);
    press(4'hE, 3, 1, 0);

    // 4a: inactivity timeout on the fifth stroke-free tick.
    press(4'h4, 3, 1, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, 1'b0);
    check("t4.before_len", 64'(code_len), 64'd1);
    step(1'b1, 4'h0, 1'b0);
    check("t4.pulse", 64'(timeout_pulse), 64'd1);
    check("t4.len", 64'(code_len), 64'd0);
    check("t4.busy", 64'(entry_busy), 64'd0);
    step(1'b1, 4'h0, 1'b0);
    check("t4.pulse_gone", 64'(timeout_pulse), 64'd0);
    // 4b: a stroke landing on the expiry edge wins.
    press(4'h4, 3, 1, 0);
    press(4'h5, 4, 1, 0);
    check("t4.race_len", 64'(code_len), 64'd2);
    check("t4.race_code", 64'(code), 64'h45);
    check("t4.race_pulse", 64'(timeout_pulse), 64'd0);
    press(4'hE, 3, 1, 0);

    // 5: strokes ignored in DELIVER; accept on an edge that also has a stroke.
    press(4'h1, 3, 1, 0);
    press(4'h2, 3, 1, 0);
    press(4'hF, 3, 1, 0);
    press(4'h7, 3, 1, 0);
    press(4'hE, 3, 1, 0);
    check("t5.code", 64'(code), 64'h12);
    check("t5.len", 64'(code_len), 64'd2);
    check("t5.valid", 64'(code_valid), 64'd1);
    press(4'h9, 3, 1, 1);
    check("t5.acc_len", 64'(code_len), 64'd0);
    check("t5.acc_valid", 64'(code_valid), 64'd0);

    // 6: asynchronous reset mid-tick, then a lone ENTER is ignored.
    press(4'hA, 3, 1, 0);
    press(4'hB, 3, 1, 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("t6.async");
    model_reset();
    key_done = 1'b1;
    @(posedge wClk20ms);
    @(negedge wClk20ms);
    rst = 1'b1;
    press(4'hF, 3, 1, 0);
    check("t6.enter_valid", 64'(code_valid), 64'd0);
    check("t6.enter_len", 64'(code_len), 64'd0);

    // Random keying with random consumer readiness.
    for (int n = 0; n < 400; n++) begin
      int r;
      int lows;
      int highs;
      logic [3:0] kc;
      r     = $urandom_range(0, 9);
      kc    = (r == 0) ? 4'hF : (r == 1) ? 4'hE : 4'($urandom_range(0, 13));
      lows  = $urandom_range(0, 4);
      highs = $urandom_range(1, 3);
      for (int i = 0; i < lows; i++)
        step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      step(1'b1, kc, ($urandom_range(0, 3) == 0));
      for (int i = 1; i < highs; i++)
        step(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
